// File: rtl/cu_pipe.sv
// cu_pipe: registered RV32I control unit with a one-entry output slot.
//
// Accepts one 32-bit instruction per valid/ready handshake and presents the
// decoded control bundle on the next cycle. The bundle is held while
// out_valid && !out_ready. A one-cycle bubble is inserted when the incoming
// instruction reads the destination of a load that was just issued. A
// synchronous flush kills the output slot and the hazard state.
//
// Optional feature (compile-time macro CU_MEXT_EN): decodes the M extension
// (funct7 = 0000001) as MUL..REMU, ALU codes 36..43. Without the macro those
// encodings decode as illegal.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 synchronous kill of output slot and hazard flag
//   in_valid/in_ready     instruction handshake; instr is the raw word
//   out_valid/out_ready   decoded bundle handshake
//   alu_cntrl             ALU operation code (63 = illegal / no ALU op)
//   rd, rs1, rs2          raw register fields
//   mem_to_reg            any load; lb: byte load (LB/LBU); sw: any store
//   jump                  JAL; lui_cntrl: LUI
//   branch_en, br_funct3  conditional branch and its condition
//   timer_en, timer_read_reg, timer_ch   timer channel control
//   illegal               undecodable instruction (all enables forced to 0)
module cu_pipe #(
  parameter int unsigned ALU_CW   = 6,
  parameter int unsigned TIMER_CH = 2,
  parameter int unsigned TCH_W    = (TIMER_CH > 1) ? $clog2(TIMER_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALU_CW-1:0] alu_cntrl,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic              mem_to_reg,
  output logic              lb,
  output logic              sw,
  output logic              jump,
  output logic              lui_cntrl,
  output logic              branch_en,
  output logic [2:0]        br_funct3,
  output logic              timer_en,
  output logic              timer_read_reg,
  output logic [TCH_W-1:0]  timer_ch,
  output logic              illegal
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpTimer  = 7'b0100101;

  localparam logic [5:0] CodeIllegal = 6'd63;

  typedef struct packed {
    logic [ALU_CW-1:0] alu;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              mem_to_reg;
    logic              lb;
    logic              sw;
    logic              jump;
    logic              lui;
    logic              br_en;
    logic [2:0]        br_f3;
    logic              t_en;
    logic              t_rr;
    logic [TCH_W-1:0]  t_ch;
    logic              ill;
  } bundle_t;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] in_rd, in_rs1, in_rs2;

  assign opc    = instr[6:0];
  assign in_rd  = instr[11:7];
  assign f3     = instr[14:12];
  assign in_rs1 = instr[19:15];
  assign in_rs2 = instr[24:20];
  assign f7     = instr[31:25];

  // Decoder
  logic [5:0]       code;
  logic             ill, is_load, use_rs1, use_rs2;
  logic             d_m2r, d_lb, d_sw, d_jump, d_lui, d_br, d_ten, d_trr;
  logic [2:0]       d_bf3;
  logic [TCH_W-1:0] d_tch;
  bundle_t          bun_d, bun_q;

  always_comb begin
    code    = CodeIllegal;
    ill     = 1'b0;
    is_load = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    d_m2r   = 1'b0;
    d_lb    = 1'b0;
    d_sw    = 1'b0;
    d_jump  = 1'b0;
    d_lui   = 1'b0;
    d_br    = 1'b0;
    d_bf3   = 3'b000;
    d_ten   = 1'b0;
    d_trr   = 1'b0;
    d_tch   = '0;

    case (opc)
      OpR: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  code = 6'd0;
            3'b001:  code = 6'd2;
            3'b010:  code = 6'd3;
            3'b011:  code = 6'd4;
            3'b100:  code = 6'd5;
            3'b101:  code = 6'd6;
            3'b110:  code = 6'd8;
            default: code = 6'd9;
          endcase
        end else if (f7 == 7'b0100000) begin
          // Only SUB and SRA exist with the alternate funct7.
          if (f3 == 3'b000)      code = 6'd1;
          else if (f3 == 3'b101) code = 6'd7;
          else                   ill  = 1'b1;
        end
`ifdef CU_MEXT_EN
        else if (f7 == 7'b0000001) begin
          code = 6'd36 + {3'b000, f3};
        end
`endif
        else begin
          ill = 1'b1;
        end
      end
      OpImm: begin
        use_rs1 = 1'b1;
        // SRLI/SRAI share code 15, so the I-type codes are a plain offset.
        code = 6'd10 + {3'b000, f3};
      end
      OpLoad: begin
        use_rs1 = 1'b1;
        is_load = 1'b1;
        d_m2r   = 1'b1;
        case (f3)
          3'b000:  begin code = 6'd18; d_lb = 1'b1; end
          3'b001:  code = 6'd19;
          3'b010:  code = 6'd20;
          3'b100:  begin code = 6'd21; d_lb = 1'b1; end
          3'b101:  code = 6'd22;
          default: ill  = 1'b1;
        endcase
      end
      OpStore: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        d_sw    = 1'b1;
        if (f3 < 3'b011) code = 6'd23 + {3'b000, f3};
        else             ill  = 1'b1;
      end
      OpBranch: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        d_br    = 1'b1;
        d_bf3   = f3;
        case (f3)
          3'b000:  code = 6'd26;
          3'b001:  code = 6'd27;
          3'b100:  code = 6'd28;
          3'b101:  code = 6'd29;
          3'b110:  code = 6'd30;
          3'b111:  code = 6'd31;
          default: ill  = 1'b1;
        endcase
      end
      OpJal: begin
        d_jump = 1'b1;
        code   = 6'd32;
      end
      OpLui: begin
        d_lui = 1'b1;
        code  = 6'd35;
      end
      OpTimer: begin
        use_rs1 = 1'b1;
        d_tch   = f7[TCH_W-1:0];
        if ({25'd0, f7} >= TIMER_CH) ill = 1'b1;
        // Enable/disable carry no ALU operation and keep code 63.
        case (f3)
          3'b000:  d_ten = 1'b1;
          3'b001:  begin d_ten = 1'b1; code = 6'd33; end
          3'b010:  begin d_ten = 1'b1; code = 6'd34; end
          3'b100:  begin d_ten = 1'b1; d_trr = 1'b1; code = 6'd33; end
          3'b101:  begin d_ten = 1'b1; d_trr = 1'b1; code = 6'd34; end
          3'b111:  d_ten = 1'b0;
          default: ill   = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase

    // Illegal words keep their register fields but drive no enables.
    if (ill) begin
      code    = CodeIllegal;
      is_load = 1'b0;
      d_m2r   = 1'b0;
      d_lb    = 1'b0;
      d_sw    = 1'b0;
      d_jump  = 1'b0;
      d_lui   = 1'b0;
      d_br    = 1'b0;
      d_bf3   = 3'b000;
      d_ten   = 1'b0;
      d_trr   = 1'b0;
      d_tch   = '0;
    end

    bun_d = '{
      alu:        ALU_CW'(code),
      rd:         in_rd,
      rs1:        in_rs1,
      rs2:        in_rs2,
      mem_to_reg: d_m2r,
      lb:         d_lb,
      sw:         d_sw,
      jump:       d_jump,
      lui:        d_lui,
      br_en:      d_br,
      br_f3:      d_bf3,
      t_en:       d_ten,
      t_rr:       d_trr,
      t_ch:       d_tch,
      ill:        ill
    };
  end

  // Handshake and load-use hazard
  logic       out_valid_q;
  logic       haz_q;
  logic [4:0] rd_last_q;
  logic       free, stall, xfer;

  assign free  = !out_valid_q || out_ready;
  assign stall = haz_q && in_valid &&
                 ((use_rs1 && (in_rs1 == rd_last_q)) || (use_rs2 && (in_rs2 == rd_last_q)));
  assign in_ready = free && !flush && !stall;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      haz_q       <= 1'b0;
      rd_last_q   <= 5'd0;
      bun_q       <= '0;
      bun_q.alu   <= '1;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      haz_q       <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      bun_q       <= bun_d;
      haz_q       <= is_load && (in_rd != 5'd0);
      rd_last_q   <= in_rd;
    end else if (free) begin
      out_valid_q <= 1'b0;
      // A stall with a free slot is the bubble; the hazard is then resolved.
      if (stall) haz_q <= 1'b0;
    end
  end

  assign out_valid      = out_valid_q;
  assign alu_cntrl      = bun_q.alu;
  assign rd             = bun_q.rd;
  assign rs1            = bun_q.rs1;
  assign rs2            = bun_q.rs2;
  assign mem_to_reg     = bun_q.mem_to_reg;
  assign lb             = bun_q.lb;
  assign sw             = bun_q.sw;
  assign jump           = bun_q.jump;
  assign lui_cntrl      = bun_q.lui;
  assign branch_en      = bun_q.br_en;
  assign br_funct3      = bun_q.br_f3;
  assign timer_en       = bun_q.t_en;
  assign timer_read_reg = bun_q.t_rr;
  assign timer_ch       = bun_q.t_ch;
  assign illegal        = bun_q.ill;

endmodule

// File: tb/tb_cu_pipe.sv
// Self-checking bench for cu_pipe (default parameters: ALU_CW=6, TIMER_CH=2).
// Expected bundles are produced by a reference decoder at acceptance time,
// queued, and compared when the DUT hands the bundle downstream.
module tb_cu_pipe;

  localparam int BW = 34;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        in_ready, out_valid;
  logic [5:0]  alu_cntrl;
  logic [4:0]  rd, rs1, rs2;
  logic        mem_to_reg, lb, sw, jump, lui_cntrl, branch_en;
  logic [2:0]  br_funct3;
  logic        timer_en, timer_read_reg, illegal;
  logic [0:0]  timer_ch;

  cu_pipe dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instr          (instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_cntrl      (alu_cntrl),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .mem_to_reg     (mem_to_reg),
    .lb             (lb),
    .sw             (sw),
    .jump           (jump),
    .lui_cntrl      (lui_cntrl),
    .branch_en      (branch_en),
    .br_funct3      (br_funct3),
    .timer_en       (timer_en),
    .timer_read_reg (timer_read_reg),
    .timer_ch       (timer_ch),
    .illegal        (illegal)
  );

  always #5 clk = ~clk;

  wire [BW-1:0] obs = {alu_cntrl, rd, rs1, rs2, mem_to_reg, lb, sw, jump, lui_cntrl,
                       branch_en, br_funct3, timer_en, timer_read_reg, timer_ch, illegal};

  int checks = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];

  localparam int RTAB[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  // Reference decoder written from the opcode/funct tables.
  function automatic logic [BW-1:0] model(input logic [31:0] i);
    logic [6:0] op, f7;
    logic [2:0] f3, bf3;
    int         alu;
    logic       ill, m2r, lbf, swf, jf, lf, bf, tf, trf, tch;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    alu = 63; ill = 0; m2r = 0; lbf = 0; swf = 0; jf = 0; lf = 0; bf = 0;
    tf = 0; trf = 0; tch = 0; bf3 = 3'b000;
    case (op)
      7'b0110011: begin
        if (f7 == 7'h00) alu = RTAB[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) alu = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 7;
`ifdef CU_MEXT_EN
        else if (f7 == 7'h01) alu = 36 + int'(f3);
`endif
        else ill = 1;
      end
      7'b0010011: alu = 10 + int'(f3);
      7'b0000011: begin
        m2r = 1;
        case (f3)
          3'd0: begin alu = 18; lbf = 1; end
          3'd1: alu = 19;
          3'd2: alu = 20;
          3'd4: begin alu = 21; lbf = 1; end
          3'd5: alu = 22;
          default: ill = 1;
        endcase
      end
      7'b0100011: begin
        swf = 1;
        if (f3 <= 3'd2) alu = 23 + int'(f3); else ill = 1;
      end
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
        else begin
          bf = 1; bf3 = f3;
          alu = (f3 < 3'd4) ? 26 + int'(f3) : 24 + int'(f3);
        end
      end
      7'b1101111: begin jf = 1; alu = 32; end
      7'b0110111: begin lf = 1; alu = 35; end
      7'b0100101: begin
        if (f7 >= 7'd2) ill = 1;
        tch = f7[0];
        case (f3)
          3'd0: tf = 1;
          3'd1: begin tf = 1; alu = 33; end
          3'd2: begin tf = 1; alu = 34; end
          3'd4: begin tf = 1; trf = 1; alu = 33; end
          3'd5: begin tf = 1; trf = 1; alu = 34; end
          3'd7: tf = 0;
          default: ill = 1;
        endcase
      end
      default: ill = 1;
    endcase
    if (ill) begin
      alu = 63; m2r = 0; lbf = 0; swf = 0; jf = 0; lf = 0; bf = 0; bf3 = 3'b000;
      tf = 0; trf = 0; tch = 0;
    end
    return {6'(alu), i[11:7], i[19:15], i[24:20], m2r, lbf, swf, jf, lf, bf, bf3,
            tf, trf, tch, ill};
  endfunction

  // Drive one cycle's inputs at the falling edge and sample 1 time unit later.
  // acc: instruction accepted at the coming edge (expected value queued).
  // took: bundle handed downstream at the coming edge (expected popped into e).
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                      input logic fl, output logic acc, output logic took,
                      output logic [BW-1:0] got, output logic have_e,
                      output logic [BW-1:0] e);
    @(negedge clk);
    in_valid = v; instr = ins; out_ready = ordy; flush = fl;
    #1;
    took = out_valid && out_ready;
    got = obs;
    have_e = 1'b0;
    e = '0;
    if (took && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      have_e = 1'b1;
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(ins));
  endtask

  task automatic test_reset();
    logic [BW-1:0] rst_val;
    rst_val = {6'h3F, 28'd0};
    reset_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({out_valid, obs} !== {1'b0, rst_val}) begin
      failures++;
      $display("FAIL reset_state: got valid=%b bundle=%h required valid=0 bundle=%h",
               out_valid, obs, rst_val);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_decode();
    logic [31:0] tbl[16] = '{
      32'h002081B3, 32'h402081B3, 32'h40209133, 32'h00500093, 32'h0020A023,
      32'h123453B7, 32'h000000EF, 32'h0020D063, 32'h0020A063, 32'hFFFFFFFF,
      32'h02009025, 32'h04009025, 32'h0200C025, 32'h0200B025, 32'h023100B3,
      32'h00000013};
    logic acc, took, have_e;
    logic [BW-1:0] got, e;
    for (int k = 0; k <= 16; k++) begin
      step((k < 16), (k < 16) ? tbl[k] : 32'd0, 1'b1, 1'b0, acc, took, got, have_e, e);
      if (k < 16) begin
        checks++;
        if (acc !== 1'b1) begin
          failures++;
          $display("FAIL decode_accept[%0d]: got in_ready=%b required 1", k, in_ready);
        end
      end
      if (k > 0) begin
        checks++;
        if (!took || !have_e || got !== e) begin
          failures++;
          $display("FAIL decode[%0d]: got took=%b bundle=%h required %h", k - 1, took, got, e);
        end
      end
    end
  endtask

  task automatic test_load_use();
    logic acc, took, have_e;
    logic [BW-1:0] got, e;
    step(1'b1, 32'h0000A283, 1'b1, 1'b0, acc, took, got, have_e, e);   // LW x5,0(x1)
    step(1'b1, 32'h00228333, 1'b1, 1'b0, acc, took, got, have_e, e);   // ADD x6,x5,x2
    checks++;
    if (!took || !have_e || got !== e || acc !== 1'b0) begin
      failures++;
      $display("FAIL load_use_lw: got took=%b acc=%b bundle=%h required took=1 acc=0 %h",
               took, acc, got, e);
    end
    step(1'b1, 32'h00228333, 1'b1, 1'b0, acc, took, got, have_e, e);
    checks++;
    if (out_valid !== 1'b0 || acc !== 1'b1) begin
      failures++;
      $display("FAIL load_use_bubble: got out_valid=%b acc=%b required 0 1", out_valid, acc);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0, acc, took, got, have_e, e);
    checks++;
    if (!took || !have_e || got !== e) begin
      failures++;
      $display("FAIL load_use_add: got took=%b bundle=%h required %h", took, got, e);
    end
    // Load to x0 never creates a hazard.
    step(1'b1, 32'h0000A003, 1'b1, 1'b0, acc, took, got, have_e, e);
    step(1'b1, 32'h00200333, 1'b1, 1'b0, acc, took, got, have_e, e);
    checks++;
    if (!took || !have_e || got !== e || acc !== 1'b1) begin
      failures++;
      $display("FAIL load_x0_nobubble: got took=%b acc=%b bundle=%h required 1 1 %h",
               took, acc, got, e);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0, acc, took, got, have_e, e);
    checks++;
    if (!took || !have_e || got !== e) begin
      failures++;
      $display("FAIL load_x0_add: got took=%b bundle=%h required %h", took, got, e);
    end
  endtask

  task automatic test_backpressure();
    logic acc, took, have_e;
    logic [BW-1:0] got, e;
    logic [12:0] seen;
    step(1'b1, 32'h0020D063, 1'b0, 1'b0, acc, took, got, have_e, e);   // BGE x1,x2
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 32'h00500093, 1'b0, 1'b0, acc, took, got, have_e, e); // ADDI held off
      seen = {out_valid, acc, alu_cntrl, branch_en, br_funct3};
      checks++;
      if (seen !== {1'b1, 1'b0, 6'd29, 1'b1, 3'd5}) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: got %b required %b", c, seen,
                 {1'b1, 1'b0, 6'd29, 1'b1, 3'd5});
      end
    end
    step(1'b1, 32'h00500093, 1'b1, 1'b0, acc, took, got, have_e, e);
    checks++;
    if (!took || !have_e || got !== e || acc !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: got took=%b acc=%b bundle=%h required 1 1 %h",
               took, acc, got, e);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0, acc, took, got, have_e, e);
    checks++;
    if (!took || !have_e || got !== e) begin
      failures++;
      $display("FAIL backpressure_next: got took=%b bundle=%h required %h", took, got, e);
    end
  endtask

  task automatic test_flush();
    logic acc, took, have_e;
    logic [BW-1:0] got, e;
    step(1'b1, 32'h0000A283, 1'b1, 1'b0, acc, took, got, have_e, e);   // LW x5
    step(1'b1, 32'h00228333, 1'b0, 1'b1, acc, took, got, have_e, e);   // flush cycle
    checks++;
    if (acc !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_cycle: got acc=%b out_valid=%b required 0 1", acc, out_valid);
    end
    exp_q.delete();   // the LW bundle is killed by the flush
    step(1'b1, 32'h00228333, 1'b1, 1'b0, acc, took, got, have_e, e);
    checks++;
    if (out_valid !== 1'b0 || acc !== 1'b1) begin
      failures++;
      $display("FAIL flush_nobubble: got out_valid=%b acc=%b required 0 1", out_valid, acc);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0, acc, took, got, have_e, e);
    checks++;
    if (!took || !have_e || got !== e) begin
      failures++;
      $display("FAIL flush_dependent: got took=%b bundle=%h required %h", took, got, e);
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, took, have_e;
    logic [BW-1:0] got, e;
    step(1'b1, 32'h00500093, 1'b0, 1'b0, acc, took, got, have_e, e);
    step(1'b0, 32'd0, 1'b0, 1'b0, acc, took, got, have_e, e);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, obs} !== {1'b0, 6'h3F, 28'd0}) begin
      failures++;
      $display("FAIL reset_midflight: got valid=%b bundle=%h required 0 %h", out_valid, obs,
               {6'h3F, 28'd0});
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random_stream();
    logic [31:0] tbl[10] = '{
      32'h0000A283, 32'h00228333, 32'h00030383, 32'h0070A023, 32'h002081B3,
      32'h0020D063, 32'h02009025, 32'h123453B7, 32'h0000A283, 32'h00528333};
    logic acc, took, have_e;
    logic [BW-1:0] got, e;
    int tries;
    for (int k = 0; k < 10; k++) begin
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 20) begin
        step(1'b1, tbl[k], 1'($urandom_range(0, 1)), 1'b0, acc, took, got, have_e, e);
        tries++;
        if (took) begin
          checks++;
          if (!have_e || got !== e) begin
            failures++;
            $display("FAIL stream_out: got %h required %h (have=%b)", got, e, have_e);
          end
        end
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL stream_accept[%0d]: got no accept in 20 cycles required accept", k);
      end
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step(1'b0, 32'd0, 1'b1, 1'b0, acc, took, got, have_e, e);
      if (took) begin
        checks++;
        if (!have_e || got !== e) begin
          failures++;
          $display("FAIL stream_drain: got %h required %h (have=%b)", got, e, have_e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL stream_empty: got %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reset_midflight();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
